stream_mux_nx1: RTL and testbench

Parametrised N-to-1, WIDTH-bit stream multiplexer with valid/ready handshaking on every input and on the output. It selects one source per cycle, either from an externally driven select or by a built-in round-robin arbiter. Each accepted word is registered into a 2-entry output skid buffer and tagged with its source index. It sits between the SAD/candidate-block producers and the shared downstream datapath in the VBSME pipeline, replacing ad-hoc combinational 2:1 word muxes where back-pressure matters.

---
 rtl/stream_mux_nx1_pkg.sv | 22 ++
 rtl/stream_mux_nx1_arb.sv | 40 ++++
 rtl/stream_mux_nx1.sv | 114 +++++++++++
 tb/tb_stream_mux_nx1.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_nx1_pkg.sv
// Shared definitions for the stream multiplexer and its round-robin arbiter.
`timescale 1ns/1ps
package stream_mux_nx1_pkg;

  // Grant source selection.
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // The output skid buffer holds this many words.
  localparam int BUF_DEPTH = 2;

  // Ceiling log2, clamped to at least 1 so that index ports never collapse to zero width.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/stream_mux_nx1_arb.sv
// Combinational round-robin arbiter: grants the first requester after ptr, wrapping.
`timescale 1ns/1ps
module rr_arbiter
  import stream_mux_nx1_pkg::*;
#(
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  input  logic              en,
  output logic [NUM_IN-1:0] gnt,
  output logic [SEL_W-1:0]  gnt_idx
);

  logic w_found;

  // Search channels above ptr first, then wrap to the channels at or below it.
  always_comb begin
    // NOTE: every output gets a default before any condition, so no path leaves a latch.
    gnt     = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (en && !w_found && req[i] && (i > int'(ptr))) begin
        w_found = 1'b1;
        gnt[i]  = 1'b1;
        gnt_idx = SEL_W'(i);
      end
    end
    for (int i = 0; i < NUM_IN; i++) begin
      if (en && !w_found && req[i] && (i <= int'(ptr))) begin
        w_found = 1'b1;
        gnt[i]  = 1'b1;
        gnt_idx = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/stream_mux_nx1.sv
// N-to-1 valid/ready stream mux with fixed or round-robin selection and a 2-entry output skid buffer.
`timescale 1ns/1ps
module stream_mux_nx1
  import stream_mux_nx1_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = clog2(NUM_IN)
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  output logic                    out_valid,
  input  logic                    out_ready
);

  // Skid buffer: entry 0 is always the head shown on the outputs.
  logic [1:0]       r_count;
  logic [WIDTH-1:0] r_data [BUF_DEPTH];
  logic [SEL_W-1:0] r_src  [BUF_DEPTH];
  logic [SEL_W-1:0] r_ptr;

  logic [NUM_IN-1:0] w_rr_gnt;
  logic [SEL_W-1:0]  w_rr_idx;
  logic [NUM_IN-1:0] w_fix_gnt;
  logic [NUM_IN-1:0] w_gnt;
  logic [SEL_W-1:0]  w_gnt_idx;
  logic              w_can_push;
  logic              w_push;
  logic              w_pop;
  logic [WIDTH-1:0]  w_push_data;

  rr_arbiter #(.NUM_IN(NUM_IN)) u_arb (
    .req     (in_valid),
    .ptr     (r_ptr),
    .en      (mode == MODE_RR),
    .gnt     (w_rr_gnt),
    .gnt_idx (w_rr_idx)
  );

  // Decode the fixed select; an index beyond NUM_IN matches no channel and so grants nothing.
  always_comb begin
    w_fix_gnt = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (int'(sel) == i) w_fix_gnt[i] = 1'b1;
    end
  end

  // Ready depends only on registered count, reset and the grant, never on out_ready.
  assign w_gnt      = (mode == MODE_RR) ? w_rr_gnt : w_fix_gnt;
  assign w_gnt_idx  = (mode == MODE_RR) ? w_rr_idx : sel;
  assign w_can_push = Rst && (r_count < 2'(BUF_DEPTH));
  assign in_ready   = w_can_push ? w_gnt : '0;
  assign w_push     = |(in_valid & in_ready);
  assign w_pop      = out_valid && out_ready;

  // Select the granted channel's word.
  always_comb begin
    w_push_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (w_gnt[i]) w_push_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Skid buffer, occupancy count and round-robin pointer.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_count <= '0;
      r_ptr   <= SEL_W'(NUM_IN - 1);
      // NOTE: the buffer entries are reset too, because the head drives out_data, which must read 0 after reset.
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_data[i] <= '0;
        r_src[i]  <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (w_push) r_ptr <= w_gnt_idx;
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_data[0] <= w_push_data;
            r_src[0]  <= w_gnt_idx;
          end else begin
            r_data[1] <= w_push_data;
            r_src[1]  <= w_gnt_idx;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_data[0] <= r_data[1];
          r_src[0]  <= r_src[1];
          r_count   <= r_count - 2'd1;
        end
        2'b11: begin
          // Only reachable with one word held: the new word replaces the departing head.
          r_data[0] <= w_push_data;
          r_src[0]  <= w_gnt_idx;
        end
        default: ;
      endcase
    end
  end

  assign out_valid = (r_count != 2'd0);
  assign out_data  = r_data[0];
  assign out_src   = r_src[0];

endmodule

// File: tb/tb_stream_mux_nx1.sv
// Self-checking bench: queue-based reference model, directed scenarios, then randomized traffic.
`timescale 1ns/1ps
module tb_stream_mux_nx1;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int SW = 2;

  logic           Clk = 1'b0;
  logic           Rst = 1'b0;
  logic           mode = 1'b0;
  logic [SW-1:0]  sel = '0;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]   in_valid = '0;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_src;
  logic           out_valid;
  logic           out_ready = 1'b0;

  // Three-channel instance for the out-of-range select case.
  logic           mode3 = 1'b0;
  logic [1:0]     sel3 = 2'd3;
  logic [3*W-1:0] in_data3 = '0;
  logic [2:0]     in_valid3 = 3'b111;
  logic [2:0]     in_ready3;
  logic [W-1:0]   out_data3;
  logic [1:0]     out_src3;
  logic           out_valid3;
  logic           out_ready3 = 1'b1;

  stream_mux_nx1 #(.WIDTH(W), .NUM_IN(N)) u_dut (
    .Clk(Clk), .Rst(Rst), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_src(out_src), .out_valid(out_valid), .out_ready(out_ready)
  );

  stream_mux_nx1 #(.WIDTH(W), .NUM_IN(3)) u_dut3 (
    .Clk(Clk), .Rst(Rst), .mode(mode3), .sel(sel3),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_src(out_src3), .out_valid(out_valid3), .out_ready(out_ready3)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the buffer is a plain queue of {word, source}.
  typedef struct {
    logic [W-1:0] data;
    int           src;
  } entry_t;

  entry_t m_q[$];
  int     m_ptr  = N - 1;
  bit     m_zero = 1'b1;
  bit     chk_en = 1'b0;

  function automatic int exp_grant();
    if (mode == 1'b0) return (int'(sel) < N) ? int'(sel) : -1;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (in_valid[2'(idx)]) return idx;
    end
    return -1;
  endfunction

  task automatic model_step();
    int g;
    bit push;
    bit pop;
    if (!Rst) begin
      m_q.delete();
      m_ptr  = N - 1;
      m_zero = 1'b1;
    end else begin
      g    = exp_grant();
      push = (g >= 0) && in_valid[2'(g)] && (m_q.size() < 2);
      pop  = (m_q.size() > 0) && out_ready;
      if (pop) void'(m_q.pop_front());
      if (push) begin
        m_q.push_back('{data: in_data[g*W +: W], src: g});
        m_ptr  = g;
        m_zero = 1'b0;
      end
    end
  endtask

  task automatic model_check();
    int g;
    logic [N-1:0] er;
    g  = exp_grant();
    er = (Rst && (m_q.size() < 2) && (g >= 0)) ? N'(1 << g) : '0;
    check("model in_ready", 64'(in_ready), 64'(er));
    check("model out_valid", 64'(out_valid), 64'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      check("model out_data", 64'(out_data), 64'(m_q[0].data));
      check("model out_src", 64'(out_src), 64'(m_q[0].src));
    end else if (m_zero) begin
      check("model idle out_data", 64'(out_data), 64'd0);
      check("model idle out_src", 64'(out_src), 64'd0);
    end
  endtask

  initial forever begin
    @(posedge Clk);
    model_step();
  end

  initial forever begin
    @(negedge Clk);
    if (chk_en) model_check();
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  logic [63:0] got[$];
  int          pushes;
  logic        rdy;

  initial begin
    for (int i = 0; i < 3; i++) in_data3[i*W +: W] = 32'h300 + 32'(i);
    tick();
    tick();
    chk_en = 1'b1;

    // Reset state
    @(negedge Clk);
    check("reset in_ready", 64'(in_ready), 64'd0);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_data", 64'(out_data), 64'd0);
    check("reset out_src", 64'(out_src), 64'd0);

    // Fixed select of channel 2
    tick();
    Rst = 1'b1; mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; out_ready = 1'b1;
    in_data[2*W +: W] = 32'hA5A5_0002;
    @(negedge Clk);
    check("fixed in_ready", 64'(in_ready), 64'h4);
    tick();
    in_valid = '0;
    @(negedge Clk);
    check("fixed out_valid", 64'(out_valid), 64'd1);
    check("fixed out_data", 64'(out_data), 64'hA5A5_0002);
    check("fixed out_src", 64'(out_src), 64'd2);
    check("oor in_ready", 64'(in_ready3), 64'd0);
    check("oor out_valid", 64'(out_valid3), 64'd0);

    // Round-robin from reset, all channels valid
    tick();
    Rst = 1'b0;
    tick();
    Rst = 1'b1; mode = 1'b1; in_valid = 4'b1111;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'h100 + 32'(i);
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k == 5) begin
        mode = 1'b0; sel = 2'd3;
      end
      @(negedge Clk);
      check("rr out_valid", 64'(out_valid), 64'd1);
      check("rr out_src", 64'(out_src), 64'(k % 4));
    end

    // Mode switch: two fixed pushes from ch3, then round-robin resumes at ch0
    tick();
    tick();
    mode = 1'b1;
    @(negedge Clk);
    check("switch out_src", 64'(out_src), 64'd3);
    check("switch in_ready", 64'(in_ready), 64'h1);
    tick();
    in_valid = '0;
    @(negedge Clk);
    check("switch grant src", 64'(out_src), 64'd0);
    tick();

    // Backpressure on channel 0
    tick();
    mode = 1'b0; sel = 2'd0; out_ready = 1'b0; in_valid = 4'b0001;
    in_data[0 +: W] = 32'd1;
    pushes = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge Clk);
      rdy = in_ready[0];
      tick();
      if (rdy) begin
        pushes++;
        in_data[0 +: W] = in_data[0 +: W] + 32'd1;
      end
    end
    @(negedge Clk);
    check("bp pushes", 64'(pushes), 64'd2);
    check("bp in_ready", 64'(in_ready[0]), 64'd0);
    check("bp out_data", 64'(out_data), 64'd1);
    tick();
    out_ready = 1'b1;
    for (int c = 0; c < 10 && got.size() < 3; c++) begin
      @(negedge Clk);
      if (out_valid) got.push_back(64'(out_data));
      rdy = in_ready[0];
      tick();
      if (rdy) in_valid = '0;
    end
    check("bp drained count", 64'(got.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      check("bp drained word", (i < got.size()) ? got[i] : 64'hDEAD, 64'(i + 1));
    end
    @(negedge Clk);
    check("bp no duplicate", 64'(out_valid), 64'd0);

    // Three-channel instance: valid select after the out-of-range one
    tick();
    sel3 = 2'd2;
    @(negedge Clk);
    check("ch3 in_ready", 64'(in_ready3), 64'h4);
    tick();
    @(negedge Clk);
    check("ch3 out_valid", 64'(out_valid3), 64'd1);
    check("ch3 out_src", 64'(out_src3), 64'd2);

    // Reset with the buffer full
    tick();
    out_ready = 1'b0; in_valid = 4'b0001; in_data[0 +: W] = 32'h55;
    tick();
    tick();
    Rst = 1'b0;
    @(negedge Clk);
    check("rst full out_valid", 64'(out_valid), 64'd1);
    check("rst comb in_ready", 64'(in_ready), 64'd0);
    tick();
    @(negedge Clk);
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst out_data", 64'(out_data), 64'd0);
    check("rst in_ready", 64'(in_ready), 64'd0);
    tick();
    Rst = 1'b1; mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    @(negedge Clk);
    check("post-rst in_ready", 64'(in_ready), 64'h1);
    tick();
    in_valid = '0;
    @(negedge Clk);
    check("post-rst out_src", 64'(out_src), 64'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      tick();
      Rst       = ($urandom_range(0, 39) != 0);
      mode      = 1'($urandom);
      sel       = 2'($urandom);
      in_valid  = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) in_data[i*W +: W] = $urandom;
    end
    tick();
    Rst = 1'b1; in_valid = '0; out_ready = 1'b1;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
